// File: rtl/fml_fb_writer_if.sv
// Signal bundle for the frame-buffer writer: pixel stream, FML initiator
// and Wishbone register port. master = writer side, slave = environment.
interface fml_fb_writer_if #(
   parameter int g_fml_depth = 26
);
   logic                   frame_start_i;
   logic [31:0]            pix_i;
   logic                   pix_valid_i;
   logic                   pix_ready_o;
   logic [g_fml_depth-1:0] fml_adr;
   logic                   fml_stb;
   logic                   fml_we;
   logic [3:0]             fml_sel;
   logic [31:0]            fml_do;
   logic                   fml_ack;
   logic [31:0]            wb_adr_i;
   logic [31:0]            wb_dat_i;
   logic [31:0]            wb_dat_o;
   logic [3:0]             wb_sel_i;
   logic                   wb_cyc_i;
   logic                   wb_stb_i;
   logic                   wb_we_i;
   logic                   wb_ack_o;
   logic                   wb_stall_o;
   logic                   done_o;

   modport master (
      input  frame_start_i, pix_i, pix_valid_i, fml_ack,
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
      output pix_ready_o, fml_adr, fml_stb, fml_we, fml_sel, fml_do,
      output wb_dat_o, wb_ack_o, wb_stall_o, done_o
   );

   modport slave (
      output frame_start_i, pix_i, pix_valid_i, fml_ack,
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
      input  pix_ready_o, fml_adr, fml_stb, fml_we, fml_sel, fml_do,
      input  wb_dat_o, wb_ack_o, wb_stall_o, done_o
   );
endinterface

// File: rtl/fml_fb_writer.sv
// Frame-buffer writer: gathers pixel words into 4-beat FML write bursts,
// configured and monitored through a small Wishbone register block.
module fml_fb_writer #(
   parameter int g_fml_depth = 26
) (
   input  logic                   clk_sys_i,
   input  logic                   rst_i,
   input  logic                   frame_start_i,
   input  logic [31:0]            pix_i,
   input  logic                   pix_valid_i,
   output logic                   pix_ready_o,
   output logic [g_fml_depth-1:0] fml_adr,
   output logic                   fml_stb,
   output logic                   fml_we,
   output logic [3:0]             fml_sel,
   output logic [31:0]            fml_do,
   input  logic                   fml_ack,
   input  logic [31:0]            wb_adr_i,
   input  logic [31:0]            wb_dat_i,
   output logic [31:0]            wb_dat_o,
   input  logic [3:0]             wb_sel_i,
   input  logic                   wb_cyc_i,
   input  logic                   wb_stb_i,
   input  logic                   wb_we_i,
   output logic                   wb_ack_o,
   output logic                   wb_stall_o,
   output logic                   done_o
);
   localparam int AW = g_fml_depth - 4;

   typedef enum logic [1:0] {IDLE, FILL, REQ, XFER} state_t;

   state_t        state_q, state_d;
   logic          en_q, en_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW-1:0] size_q, size_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] rem_q, rem_d;
   logic          done_q, done_d;
   logic          abrt_q, abrt_d;
   logic [1:0]    wcnt_q, wcnt_d;
   logic [1:0]    beat_q, beat_d;
   logic          ack_q, ack_d;
   logic [31:0]   dat_q, dat_d;
   logic [31:0]   buf_q [4];

   logic        wb_req, wb_wr, wb_rd, busy;
   logic [4:0]  reg_a;
   logic [31:0] wmask, base_v, size_v, cnt_v, rdv, merged;
   logic        unused_adr;

   assign wb_req     = wb_cyc_i && wb_stb_i;
   assign wb_wr      = wb_req && wb_we_i;
   assign wb_rd      = wb_req && !wb_we_i;
   assign reg_a      = wb_adr_i[4:0];
   assign unused_adr = ^wb_adr_i[31:5];
   assign busy       = (state_q != IDLE);
   assign wmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                        {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

   always_comb begin
      base_v = '0;
      base_v[g_fml_depth-1:4] = base_q;
      size_v = 32'(size_q);
      cnt_v  = 32'(cnt_q);
      case (reg_a)
         5'd0:    rdv = {31'b0, en_q};
         5'd4:    rdv = base_v;
         5'd8:    rdv = size_v;
         5'd12:   rdv = {29'b0, abrt_q, done_q, busy};
         5'd16:   rdv = cnt_v;
         default: rdv = '0;
      endcase
      merged = (rdv & ~wmask) | (wb_dat_i & wmask);
   end

   always_comb begin
      state_d = state_q;
      en_d    = en_q;
      base_d  = base_q;
      size_d  = size_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      done_d  = done_q;
      abrt_d  = abrt_q;
      wcnt_d  = wcnt_q;
      beat_d  = beat_q;
      ack_d   = wb_req;
      dat_d   = wb_rd ? rdv : '0;

      if (wb_wr) begin
         case (reg_a)
            5'd0:  if (wb_sel_i[0]) en_d = wb_dat_i[0];
            5'd4:  base_d = merged[g_fml_depth-1:4];
            5'd8:  size_d = merged[AW-1:0];
            5'd12: if (wb_sel_i[0]) begin
                      if (wb_dat_i[1]) done_d = 1'b0;
                      if (wb_dat_i[2]) abrt_d = 1'b0;
                   end
            default: ;
         endcase
      end

      // hardware updates come last so a same-cycle W1C loses to a set
      unique case (state_q)
         IDLE: if (frame_start_i && en_q) begin
            if (size_q != '0) begin
               addr_d  = base_q;
               rem_d   = size_q;
               cnt_d   = '0;
               done_d  = 1'b0;
               abrt_d  = 1'b0;
               wcnt_d  = 2'd0;
               state_d = FILL;
            end else begin
               done_d = 1'b1;
            end
         end
         FILL: if (pix_valid_i) begin
            wcnt_d = wcnt_q + 2'd1;
            if (wcnt_q == 2'd3) state_d = REQ;
         end
         REQ: if (fml_ack) begin
            beat_d  = 2'd1;
            state_d = XFER;
         end
         XFER: begin
            if (beat_q == 2'd3) begin
               addr_d = addr_q + AW'(1);
               cnt_d  = cnt_q + AW'(1);
               rem_d  = rem_q - AW'(1);
               wcnt_d = 2'd0;
               if (rem_q == AW'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (!en_q) begin
                  abrt_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = FILL;
               end
            end else begin
               beat_d = beat_q + 2'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         base_q  <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         abrt_q  <= 1'b0;
         wcnt_q  <= 2'd0;
         beat_q  <= 2'd0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         base_q  <= base_d;
         size_q  <= size_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         abrt_q  <= abrt_d;
         wcnt_q  <= wcnt_d;
         beat_q  <= beat_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (state_q == FILL && pix_valid_i) buf_q[wcnt_q] <= pix_i;
   end

   always_comb begin
      fml_do = '0;
      if (state_q == REQ) fml_do = buf_q[0];
      else if (state_q == XFER) fml_do = buf_q[beat_q];
   end

   assign fml_adr     = {addr_q, 4'b0};
   assign fml_stb     = (state_q == REQ);
   assign fml_we      = 1'b1;
   assign fml_sel     = 4'hF;
   assign pix_ready_o = (state_q == FILL);
   assign done_o      = done_q;
   assign wb_ack_o    = ack_q;
   assign wb_dat_o    = dat_q;
   assign wb_stall_o  = 1'b0;
endmodule
